// File: rtl/i2c_slave_rx_ctrl.sv
// I2C slave receive-path sequencer: frames transactions from START/STOP and SCL
// edge strobes, checks the address, drives the ACK slot and hands bytes to the FIFO.
module i2c_slave_rx_ctrl #(
  parameter logic [6:0]  SLAVE_ADDR = 7'h3C,
  parameter int unsigned BIT_CNT_W  = 4
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       start_found,
  input  logic       stop_found,
  input  logic       rising_edge_found,
  input  logic       falling_edge_found,
  input  logic [7:0] rx_data,
  input  logic       fifo_full,
  output logic       rx_enable,
  output logic       sda_drive_low,
  output logic       byte_valid,
  output logic [7:0] byte_out,
  output logic       addr_matched,
  output logic       overrun,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    CHK_ADDR,
    ACK_ADDR,
    DATA,
    STORE,
    ACK_DATA,
    IGNORE
  } state_t;

  localparam logic [BIT_CNT_W-1:0] BIT_CNT_FULL = BIT_CNT_W'(8);

  state_t               state, state_next;
  logic [BIT_CNT_W-1:0] bit_cnt, bit_cnt_next;
  logic                 rise_seen, rise_seen_next;
  logic                 rx_enable_next, sda_next, valid_next, matched_next;
  logic                 overrun_next, busy_next;
  logic [7:0]           byte_out_next;

  always_comb begin
    state_next     = state;
    bit_cnt_next   = bit_cnt;
    rise_seen_next = rise_seen;
    matched_next   = addr_matched;
    valid_next     = 1'b0;
    overrun_next   = 1'b0;
    byte_out_next  = byte_out;

    if (rising_edge_found && rx_enable && (bit_cnt != BIT_CNT_FULL)) begin
      bit_cnt_next = bit_cnt + BIT_CNT_W'(1);
    end

    // START beats STOP; both abort any partial byte before per-state handling.
    if (start_found) begin
      state_next     = ADDR;
      bit_cnt_next   = '0;
      rise_seen_next = 1'b0;
      matched_next   = 1'b0;
    end else if (stop_found) begin
      state_next     = IDLE;
      bit_cnt_next   = '0;
      rise_seen_next = 1'b0;
      matched_next   = 1'b0;
    end else begin
      unique case (state)
        IDLE: ;
        ADDR: begin
          if (falling_edge_found && (bit_cnt == BIT_CNT_FULL)) state_next = CHK_ADDR;
        end
        CHK_ADDR: begin
          if ((rx_data[7:1] == SLAVE_ADDR) && !rx_data[0]) begin
            state_next     = ACK_ADDR;
            matched_next   = 1'b1;
            rise_seen_next = 1'b0;
          end else begin
            state_next = IGNORE;
          end
        end
        ACK_ADDR, ACK_DATA: begin
          if (falling_edge_found && rise_seen) begin
            state_next   = DATA;
            bit_cnt_next = '0;
          end else if (rising_edge_found) begin
            rise_seen_next = 1'b1;
          end
        end
        DATA: begin
          if (falling_edge_found && (bit_cnt == BIT_CNT_FULL)) state_next = STORE;
        end
        STORE: begin
          if (!fifo_full) begin
            valid_next     = 1'b1;
            byte_out_next  = rx_data;
            state_next     = ACK_DATA;
            rise_seen_next = 1'b0;
          end else begin
            overrun_next = 1'b1;
            state_next   = IGNORE;
          end
        end
        IGNORE: ;
        default: state_next = IDLE;
      endcase
    end

    // Level outputs are decoded from the next state so each flop lines up with its state.
    rx_enable_next = (state_next == ADDR) || (state_next == DATA);
    sda_next       = (state_next == ACK_ADDR) || (state_next == ACK_DATA);
    busy_next      = (state_next != IDLE);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      rise_seen     <= 1'b0;
      rx_enable     <= 1'b0;
      sda_drive_low <= 1'b0;
      byte_valid    <= 1'b0;
      byte_out      <= 8'h00;
      addr_matched  <= 1'b0;
      overrun       <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_next;
      bit_cnt       <= bit_cnt_next;
      rise_seen     <= rise_seen_next;
      rx_enable     <= rx_enable_next;
      sda_drive_low <= sda_next;
      byte_valid    <= valid_next;
      byte_out      <= byte_out_next;
      addr_matched  <= matched_next;
      overrun       <= overrun_next;
      busy          <= busy_next;
    end
  end

endmodule

// File: tb/tb_i2c_slave_rx_ctrl.sv
// Self-checking bench for i2c_slave_rx_ctrl: table vectors, hand-written corner
// sequences and randomized transactions checked against a transaction-level model.
module tb_i2c_slave_rx_ctrl;

  localparam logic [6:0] SLAVE = 7'h3C;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       start_found = 1'b0, stop_found = 1'b0;
  logic       rising_edge_found = 1'b0, falling_edge_found = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       fifo_full = 1'b0;
  logic       sda_bit = 1'b0;
  logic       rx_enable, sda_drive_low, byte_valid, addr_matched, overrun, busy;
  logic [7:0] byte_out;

  int unsigned n_checks = 0, n_pass = 0;
  int unsigned valid_seen = 0, ovr_seen = 0;
  logic [7:0]  got_q[$];

  always #5 clk = ~clk;

  i2c_slave_rx_ctrl #(.SLAVE_ADDR(SLAVE), .BIT_CNT_W(4)) dut (
    .clk(clk), .n_rst(n_rst),
    .start_found(start_found), .stop_found(stop_found),
    .rising_edge_found(rising_edge_found), .falling_edge_found(falling_edge_found),
    .rx_data(rx_data), .fifo_full(fifo_full),
    .rx_enable(rx_enable), .sda_drive_low(sda_drive_low),
    .byte_valid(byte_valid), .byte_out(byte_out),
    .addr_matched(addr_matched), .overrun(overrun), .busy(busy)
  );

  // Environment receive shift register, MSB first.
  always @(posedge clk) begin
    if (rising_edge_found && rx_enable) rx_data <= {rx_data[6:0], sda_bit};
  end

  always @(negedge clk) begin
    if (byte_valid) begin
      valid_seen++;
      got_q.push_back(byte_out);
    end
    if (overrun) ovr_seen++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic gap(input int unsigned n);
    repeat (n) tick();
  endtask

  task automatic pulse_rise();  rising_edge_found = 1'b1;  tick(); rising_edge_found = 1'b0;  endtask
  task automatic pulse_fall();  falling_edge_found = 1'b1; tick(); falling_edge_found = 1'b0; endtask
  task automatic pulse_start(); start_found = 1'b1;        tick(); start_found = 1'b0;        endtask
  task automatic pulse_stop();  stop_found = 1'b1;         tick(); stop_found = 1'b0;         endtask

  task automatic send_bit(input logic b);
    sda_bit = b;
    gap(1);
    pulse_rise();
    gap(2);
    pulse_fall();
  endtask

  task automatic send_bits(input logic [7:0] b, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) send_bit(b[7-i]);
  endtask

  task automatic ack_slot(input logic exp_ack, input string tag);
    gap(1);
    pulse_rise();
    chk({tag, ".sda_mid"}, sda_drive_low, exp_ack);
    gap(2);
    pulse_fall();
    chk({tag, ".sda_rel"}, sda_drive_low, 1'b0);
    chk({tag, ".rx_en"}, rx_enable, exp_ack);
  endtask

  task automatic expect_idle(input string tag);
    chk({tag, ".busy"}, busy, 1'b0);
    chk({tag, ".rx_en"}, rx_enable, 1'b0);
    chk({tag, ".sda"}, sda_drive_low, 1'b0);
    chk({tag, ".match"}, addr_matched, 1'b0);
  endtask

  // Reference model: transaction outcome from the protocol rules.
  function automatic void model(input logic [7:0] addr, input int unsigned n,
                                input logic [2:0] ff, output logic ack,
                                output int unsigned nv, output int unsigned no);
    ack = (addr[7:1] == SLAVE) && (addr[0] == 1'b0);
    nv = 0;
    no = 0;
    if (ack) begin
      for (int unsigned i = 0; i < n; i++) begin
        if (ff[i]) begin
          no = 1;
          break;
        end
        nv++;
      end
    end
  endfunction

  task automatic run_txn(input logic [7:0] addr, input int unsigned n,
                         input logic [2:0][7:0] d, input logic [2:0] ff,
                         input logic exp_ack, input int unsigned exp_valid,
                         input int unsigned exp_ovr, input string tag);
    int unsigned v0, o0;
    logic alive, ev, eo;
    logic [7:0] exp_q[$];
    v0 = valid_seen;
    o0 = ovr_seen;
    got_q.delete();
    pulse_start();
    chk({tag, ".start_busy"}, busy, 1'b1);
    chk({tag, ".start_rxen"}, rx_enable, 1'b1);
    chk({tag, ".start_match"}, addr_matched, 1'b0);
    gap(1);
    pulse_fall();
    send_bits(addr, 8);
    chk({tag, ".chk_sda"}, sda_drive_low, 1'b0);
    chk({tag, ".chk_rxen"}, rx_enable, 1'b0);
    tick();
    chk({tag, ".addr_ack"}, sda_drive_low, exp_ack);
    chk({tag, ".addr_match"}, addr_matched, exp_ack);
    ack_slot(exp_ack, {tag, ".aslot"});
    alive = exp_ack;
    for (int unsigned i = 0; i < n; i++) begin
      fifo_full = ff[i];
      send_bits(d[i], 8);
      chk({tag, ".bv_early"}, byte_valid, 1'b0);
      tick();
      ev = alive && !ff[i];
      eo = alive && ff[i];
      chk({tag, ".bv"}, byte_valid, ev);
      chk({tag, ".ovr"}, overrun, eo);
      if (ev) begin
        chk({tag, ".byte"}, byte_out, d[i]);
        exp_q.push_back(d[i]);
      end
      chk({tag, ".dack"}, sda_drive_low, ev);
      if (eo) alive = 1'b0;
      ack_slot(ev, {tag, ".dslot"});
      fifo_full = 1'b0;
    end
    gap(1);
    chk({tag, ".n_valid"}, valid_seen - v0, exp_valid);
    chk({tag, ".n_ovr"}, ovr_seen - o0, exp_ovr);
    chk({tag, ".q_len"}, got_q.size(), exp_q.size());
    for (int unsigned i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk({tag, ".q_byte"}, got_q[i], exp_q[i]);
  endtask

  typedef struct {
    logic [7:0]      addr;
    int unsigned     n;
    logic [2:0][7:0] d;
    logic [2:0]      ff;
    logic            stop_after;
    logic            exp_ack;
    int unsigned     exp_valid;
    int unsigned     exp_ovr;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [7:0]      r_addr;
    int unsigned     r_n, r_nv, r_no, v0;
    logic [2:0][7:0] r_d;
    logic [2:0]      r_ff;
    logic            r_ack;

    vecs[0] = '{8'h78, 2, {8'h00, 8'h5A, 8'hA5}, 3'b000, 1'b1, 1'b1, 2, 0};
    vecs[1] = '{8'h7A, 1, {8'h00, 8'h00, 8'h11}, 3'b000, 1'b1, 1'b0, 0, 0};
    vecs[2] = '{8'h79, 1, {8'h00, 8'h00, 8'h22}, 3'b000, 1'b1, 1'b0, 0, 0};
    vecs[3] = '{8'h78, 1, {8'h00, 8'h00, 8'hFF}, 3'b001, 1'b0, 1'b1, 0, 1};
    vecs[4] = '{8'h78, 2, {8'h00, 8'h3C, 8'h00}, 3'b010, 1'b1, 1'b1, 1, 1};

    #12;
    chk("rst.byte_out", byte_out, 8'h00);
    chk("rst.bv", byte_valid, 1'b0);
    chk("rst.ovr", overrun, 1'b0);
    expect_idle("rst");
    n_rst = 1'b1;
    tick();

    for (int unsigned k = 0; k < 5; k++) begin
      run_txn(vecs[k].addr, vecs[k].n, vecs[k].d, vecs[k].ff, vecs[k].exp_ack,
              vecs[k].exp_valid, vecs[k].exp_ovr, $sformatf("vec%0d", k));
      if (vecs[k].stop_after) begin
        pulse_stop();
        expect_idle($sformatf("vec%0d.stop", k));
      end
    end

    // Asynchronous reset while driving the address ACK.
    pulse_start();
    gap(1);
    pulse_fall();
    send_bits(8'h78, 8);
    tick();
    chk("arst.pre_sda", sda_drive_low, 1'b1);
    #3 n_rst = 1'b0;
    #1;
    expect_idle("arst");
    chk("arst.byte_out", byte_out, 8'h00);
    #3 n_rst = 1'b1;
    tick();
    run_txn(8'h78, 1, {8'h00, 8'h00, 8'hC7}, 3'b000, 1'b1, 1, 0, "arst.after");
    pulse_stop();

    // STOP after 4 data bits aborts the byte.
    v0 = valid_seen;
    pulse_start();
    gap(1);
    pulse_fall();
    send_bits(8'h78, 8);
    tick();
    ack_slot(1'b1, "abort.aslot");
    send_bits(8'hC3, 4);
    pulse_stop();
    expect_idle("abort.stop");
    gap(4);
    chk("abort.no_bv", valid_seen - v0, 0);

    // Partial data byte, then coincident START+STOP: START wins and bit count restarts.
    pulse_start();
    gap(1);
    pulse_fall();
    send_bits(8'h78, 8);
    tick();
    ack_slot(1'b1, "ss.aslot");
    send_bits(8'h96, 4);
    start_found = 1'b1;
    stop_found = 1'b1;
    tick();
    start_found = 1'b0;
    stop_found = 1'b0;
    chk("ss.busy", busy, 1'b1);
    chk("ss.rxen", rx_enable, 1'b1);
    chk("ss.match", addr_matched, 1'b0);
    send_bits(8'h78, 7);
    chk("ss.seven_rxen", rx_enable, 1'b1);
    send_bit(1'b0);
    chk("ss.eight_rxen", rx_enable, 1'b0);
    tick();
    chk("ss.ack", sda_drive_low, 1'b1);
    ack_slot(1'b1, "ss.aslot2");
    pulse_stop();
    gap(2);
    chk("ss.no_bv", valid_seen - v0, 0);

    // Randomized transactions against the model.
    for (int unsigned k = 0; k < 16; k++) begin
      case ($urandom_range(0, 3))
        0: r_addr = 8'($urandom);
        1: r_addr = 8'h79;
        default: r_addr = 8'h78;
      endcase
      r_n = $urandom_range(1, 3);
      r_d = 24'($urandom);
      for (int unsigned i = 0; i < 3; i++) r_ff[i] = ($urandom_range(0, 4) == 0);
      model(r_addr, r_n, r_ff, r_ack, r_nv, r_no);
      run_txn(r_addr, r_n, r_d, r_ff, r_ack, r_nv, r_no, $sformatf("rnd%0d", k));
      if ($urandom_range(0, 1) == 0) begin
        pulse_stop();
        expect_idle($sformatf("rnd%0d.stop", k));
      end
    end
    pulse_stop();
    expect_idle("final");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
